operand_seq: RTL

Parametrised operand sequencer feeding the multi-function ALU: it holds a table of DEPTH operand pairs (A, B) of WIDTH bits and presents them either by direct switch selection or by stepping through the table under a valid/ready handshake. Reset loads the standard corner-case operand set. The block sits between the board switches/test controller and the ALU operand inputs.

---
 rtl/operand_seq_pkg.sv | 61 ++++++
 rtl/operand_seq_table.sv | 56 +++++
 rtl/operand_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/operand_seq_pkg.sv
// Shared types and default operand table contents for the operand sequencer.
// Build option OPERAND_SEQ_WRITE_EN (see operand_seq_table) selects a writable table.
package operand_seq_pkg;

  // Widest operand the default-entry helpers can produce; WIDTH must not exceed it.
  localparam int MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    MODE_MANUAL     = 2'b00,
    MODE_AUTO       = 2'b01,
    MODE_SINGLE     = 2'b10,
    MODE_MANUAL_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef logic [MAX_WIDTH-1:0] wide_t;

  typedef struct packed {
    wide_t a;
    wide_t b;
  } pair_t;

  function automatic wide_t ones_f(input int unsigned width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

  function automatic wide_t msb_f(input int unsigned width);
    return wide_t'(1) << (width - 1);
  endfunction

  function automatic wide_t maxp_f(input int unsigned width);
    return ones_f(width) >> 1;
  endfunction

  // Corner-case operand pair for table entry idx, masked to width bits.
  function automatic pair_t default_entry(input int unsigned idx, input int unsigned width);
    pair_t p;
    wide_t ones;
    ones = ones_f(width);
    case (idx)
      0: begin p.a = '0;                      p.b = '0;                      end
      1: begin p.a = wide_t'(32'h3);          p.b = wide_t'(32'h607);        end
      2: begin p.a = msb_f(width);            p.b = msb_f(width);            end
      3: begin p.a = maxp_f(width);           p.b = maxp_f(width);           end
      4: begin p.a = ones;                    p.b = ones;                    end
      5: begin p.a = msb_f(width);            p.b = ones;                    end
      6: begin p.a = ones;                    p.b = msb_f(width);            end
      7: begin p.a = wide_t'(32'h1234_5678);  p.b = wide_t'(32'h3333_2222);  end
      default: begin p.a = wide_t'(idx);      p.b = ~wide_t'(idx);           end
    endcase
    p.a = p.a & ones;
    p.b = p.b & ones;
    return p;
  endfunction

endpackage

// File: rtl/operand_seq_table.sv
// Operand pair storage with a combinational read port.
// OPERAND_SEQ_WRITE_EN defined: register file reloaded with defaults on reset; otherwise a constant ROM.
module operand_seq_table
  import operand_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_a_i,
  input  logic [WIDTH-1:0]         wdata_b_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rd_a_o,
  output logic [WIDTH-1:0]         rd_b_o
);

  logic [WIDTH-1:0] def_a [DEPTH];
  logic [WIDTH-1:0] def_b [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_def
    localparam pair_t DEF = default_entry(g, WIDTH);
    assign def_a[g] = DEF.a[WIDTH-1:0];
    assign def_b[g] = DEF.b[WIDTH-1:0];
  end

`ifdef OPERAND_SEQ_WRITE_EN
  logic [WIDTH-1:0] a_q [DEPTH];
  logic [WIDTH-1:0] b_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= def_a[i];
        b_q[i] <= def_b[i];
      end
    end else if (we_i) begin
      a_q[waddr_i] <= wdata_a_i;
      b_q[waddr_i] <= wdata_b_i;
    end
  end

  // Read sees the pre-edge contents, so a same-edge write returns the old value.
  assign rd_a_o = a_q[raddr_i];
  assign rd_b_o = b_q[raddr_i];
`else
  logic unused_rom;
  assign unused_rom = ^{clk_i, rst_i, we_i, waddr_i, wdata_a_i, wdata_b_i};

  assign rd_a_o = def_a[raddr_i];
  assign rd_b_o = def_b[raddr_i];
`endif

endmodule

// File: rtl/operand_seq.sv
// Operand sequencer: manual switch selection or valid/ready stepping through the table.
// Table writes exist only when OPERAND_SEQ_WRITE_EN is defined.
module operand_seq
  import operand_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     OPERAND_SEQ_CLK_xi,
  input  logic                     OPERAND_SEQ_RST_xi,
  input  logic [$clog2(DEPTH)-1:0] OPERAND_SEQ_SW_xi,
  input  logic [1:0]               OPERAND_SEQ_MODE_xi,
  input  logic                     OPERAND_SEQ_START_xi,
  input  logic                     OPERAND_SEQ_STOP_xi,
  input  logic                     OPERAND_SEQ_WE_xi,
  input  logic [$clog2(DEPTH)-1:0] OPERAND_SEQ_WADDR_xi,
  input  logic [WIDTH-1:0]         OPERAND_SEQ_WDATA_A_xi,
  input  logic [WIDTH-1:0]         OPERAND_SEQ_WDATA_B_xi,
  input  logic                     OPERAND_SEQ_READY_xi,
  output logic [WIDTH-1:0]         OPERAND_SEQ_A_xo,
  output logic [WIDTH-1:0]         OPERAND_SEQ_B_xo,
  output logic                     OPERAND_SEQ_VALID_xo,
  output logic [$clog2(DEPTH)-1:0] OPERAND_SEQ_IDX_xo,
  output logic                     OPERAND_SEQ_BUSY_xo,
  output logic                     OPERAND_SEQ_DONE_xo
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;

  logic [IW-1:0]    raddr;
  logic [WIDTH-1:0] rd_a, rd_b;
  mode_e            mode_in;
  logic             is_manual, xfer;

  assign mode_in   = mode_e'(OPERAND_SEQ_MODE_xi);
  assign is_manual = (mode_in == MODE_MANUAL) || (mode_in == MODE_MANUAL_ALT);
  // Handshake: a pair moves on an edge where VALID and READY are both high;
  // while VALID is high and READY low, A/B/IDX hold regardless of table writes.
  assign xfer      = valid_q && OPERAND_SEQ_READY_xi;

  operand_seq_table #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_table (
    .clk_i    (OPERAND_SEQ_CLK_xi),
    .rst_i    (OPERAND_SEQ_RST_xi),
    .we_i     (OPERAND_SEQ_WE_xi),
    .waddr_i  (OPERAND_SEQ_WADDR_xi),
    .wdata_a_i(OPERAND_SEQ_WDATA_A_xi),
    .wdata_b_i(OPERAND_SEQ_WDATA_B_xi),
    .raddr_i  (raddr),
    .rd_a_o   (rd_a),
    .rd_b_o   (rd_b)
  );

  // Read address depends only on state and inputs, never on the read data.
  always_comb begin
    raddr = '0;
    case (state_q)
      ST_IDLE: raddr = is_manual ? OPERAND_SEQ_SW_xi : '0;
      ST_RUN:  raddr = idx_q + IW'(1);
      default: raddr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_manual) begin
          a_d     = rd_a;
          b_d     = rd_b;
          idx_d   = OPERAND_SEQ_SW_xi;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
          if (OPERAND_SEQ_START_xi && !OPERAND_SEQ_STOP_xi) begin
            state_d = ST_RUN;
            mode_d  = mode_in;
            idx_d   = '0;
            a_d     = rd_a;
            b_d     = rd_b;
            valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        valid_d = 1'b1;
        if (OPERAND_SEQ_STOP_xi) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (mode_q == MODE_SINGLE && idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
            a_d   = rd_a;
            b_d   = rd_b;
          end
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        if (OPERAND_SEQ_STOP_xi) begin
          state_d = ST_IDLE;
        end else if (OPERAND_SEQ_START_xi) begin
          // A restart keeps the previous run mode unless a run mode is now selected.
          state_d = ST_RUN;
          if (!is_manual) mode_d = mode_in;
          idx_d   = '0;
          a_d     = rd_a;
          b_d     = rd_b;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge OPERAND_SEQ_CLK_xi) begin
    if (OPERAND_SEQ_RST_xi) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MANUAL;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign OPERAND_SEQ_A_xo     = a_q;
  assign OPERAND_SEQ_B_xo     = b_q;
  assign OPERAND_SEQ_VALID_xo = valid_q;
  assign OPERAND_SEQ_IDX_xo   = idx_q;
  assign OPERAND_SEQ_BUSY_xo  = (state_q == ST_RUN);
  assign OPERAND_SEQ_DONE_xo  = (state_q == ST_DONE);

endmodule
